// File: rtl/fp16_pkg.sv
// Shared fp16 format constants, field struct and divider state encoding.
package fp16_pkg;

  localparam int FP16_BIAS    = 15;
  localparam int FP16_EXP_W   = 5;
  localparam int FP16_MANT_W  = 10;
  localparam int FP16_EXP_MAX = 31;
  localparam logic [15:0] FP16_QNAN = 16'h7E00;

  typedef struct packed {
    logic                   sign;
    logic [FP16_EXP_W-1:0]  exp;
    logic [FP16_MANT_W-1:0] mant;
  } fp16_t;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    NORM,
    DONE
  } div_state_t;

endpackage

// File: rtl/fp16div_pack.sv
// Combinational exponent/mantissa packing of the divider quotient.
// FP16DIV_SPECIALS_EN adds NaN/inf/zero handling and exponent saturation.
module fp16div_pack
  import fp16_pkg::*;
(
  input  logic        sign,
  input  logic [4:0]  ea,
  input  logic [4:0]  eb,
  input  logic [11:0] q,
`ifdef FP16DIV_SPECIALS_EN
  input  logic        any_nan,
  input  logic        a_inf,
  input  logic        b_inf,
  input  logic        a_zero,
  input  logic        b_zero,
`endif
  output logic [15:0] res
);

  logic [9:0] mant;

  // q[11] set means the quotient is already in [1,2); otherwise shift up one
  assign mant = q[11] ? q[10:1] : q[9:0];

`ifdef FP16DIV_SPECIALS_EN
  localparam logic signed [6:0] BIAS_S    = 7'(FP16_BIAS);
  localparam logic signed [6:0] EXP_MAX_S = 7'(FP16_EXP_MAX);

  logic signed [6:0] e;
  fp16_t             r;

  always_comb begin
    e = $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS_S
        - (q[11] ? 7'sd0 : 7'sd1);
    r = '{sign: sign, exp: e[4:0], mant: mant};
    if (any_nan || (a_zero && b_zero) || (a_inf && b_inf))
      r = FP16_QNAN;
    else if (a_inf || b_zero)
      r = '{sign: sign, exp: 5'(FP16_EXP_MAX), mant: 10'd0};
    else if (a_zero || b_inf)
      r = '{sign: sign, exp: 5'd0, mant: 10'd0};
    else if (e >= EXP_MAX_S)
      r = '{sign: sign, exp: 5'(FP16_EXP_MAX), mant: 10'd0};
    else if (e <= 7'sd0)
      r = '{sign: sign, exp: 5'd0, mant: 10'd0};
  end

  assign res = r;
`else
  logic [4:0] e_field;

  // Raw mode: exponent wraps modulo 32, like the companion multiplier
  assign e_field = ea - eb + 5'(FP16_BIAS) - {4'b0000, ~q[11]};
  assign res     = {sign, e_field, (e_field == 5'd0) ? 10'd0 : mant};
`endif

endmodule

// File: rtl/fp16div.sv
// Sequential fp16 divider: restoring mantissa division, one quotient bit per clock.
// Define FP16DIV_SPECIALS_EN for IEEE-style NaN/inf/zero/overflow handling.
module fp16div
  import fp16_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [15:0] o_res
);

  div_state_t  state, state_next;
  fp16_t       a_f, b_f;
  logic        accept;
  logic        sign_q;
  logic [4:0]  ea_q, eb_q;
  logic [10:0] d_q;
  logic [11:0] r_q, q_q;
  logic [3:0]  cnt_q;
  logic [15:0] res_q, pack_res;
  logic [12:0] r_diff;
  logic        r_ge;
  logic [11:0] r_rem;
`ifdef FP16DIV_SPECIALS_EN
  logic        any_nan_q, a_inf_q, b_inf_q, a_zero_q, b_zero_q;
`endif

  assign a_f    = i_a;
  assign b_f    = i_b;
  assign accept = i_valid && o_ready;
  assign o_res  = res_q;

  // One restoring step: the borrow of R-D decides the quotient bit
  always_comb begin
    r_diff = {1'b0, r_q} - {2'b00, d_q};
    r_ge   = ~r_diff[12];
    r_rem  = r_ge ? r_diff[11:0] : r_q;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    o_ready    = 1'b0;
    o_valid    = 1'b0;
    case (state)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid) state_next = DIV;
      end
      DIV:  if (cnt_q == 4'd0) state_next = NORM;
      NORM: state_next = DONE;
      DONE: begin
        o_valid = 1'b1;
        if (i_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sign_q <= 1'b0;
      ea_q   <= '0;
      eb_q   <= '0;
      d_q    <= '0;
      r_q    <= '0;
      q_q    <= '0;
      cnt_q  <= '0;
      res_q  <= '0;
`ifdef FP16DIV_SPECIALS_EN
      any_nan_q <= 1'b0;
      a_inf_q   <= 1'b0;
      b_inf_q   <= 1'b0;
      a_zero_q  <= 1'b0;
      b_zero_q  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (accept) begin
          sign_q <= a_f.sign ^ b_f.sign;
          ea_q   <= a_f.exp;
          eb_q   <= b_f.exp;
          d_q    <= {1'b1, b_f.mant};
          r_q    <= {2'b01, a_f.mant};
          q_q    <= '0;
          cnt_q  <= 4'd11;
`ifdef FP16DIV_SPECIALS_EN
          any_nan_q <= (a_f.exp == 5'(FP16_EXP_MAX) && a_f.mant != '0) ||
                       (b_f.exp == 5'(FP16_EXP_MAX) && b_f.mant != '0);
          a_inf_q   <= (a_f.exp == 5'(FP16_EXP_MAX)) && (a_f.mant == '0);
          b_inf_q   <= (b_f.exp == 5'(FP16_EXP_MAX)) && (b_f.mant == '0);
          a_zero_q  <= (a_f.exp == 5'd0);
          b_zero_q  <= (b_f.exp == 5'd0);
`endif
        end
        DIV: begin
          q_q[cnt_q] <= r_ge;
          r_q        <= r_rem << 1;
          if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
        end
        NORM: res_q <= pack_res;
        default: ;
      endcase
    end
  end

  fp16div_pack u_pack (
    .sign    (sign_q),
    .ea      (ea_q),
    .eb      (eb_q),
    .q       (q_q),
`ifdef FP16DIV_SPECIALS_EN
    .any_nan (any_nan_q),
    .a_inf   (a_inf_q),
    .b_inf   (b_inf_q),
    .a_zero  (a_zero_q),
    .b_zero  (b_zero_q),
`endif
    .res     (pack_res)
  );

endmodule
